sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-port arbiter and cycle sequencer for the board's 8-bit asynchronous SRAM (21-bit address, active-low WE/RD).
- Shares the single SRAM between two requesters, e.g. video fetch and CPU/loader, using a req/ack handshake.
- Generates SRAM address, data-out, output-enable and strobe timing.
- Sits between the requester logic and the top-level SRAM pad tristate.

Parameters:
AW, 21, SRAM address width
DW, 8, SRAM data width
RD_CYCLES, 2, cycles the address is held with rd_n low before data is sampled (min 1)
WE_CYCLES, 2, cycles sram_we_n is held low during a write (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held high with p0_we/addr/wdata stable until p0_ack
p0_we  in  1  port 0: 1 = write, 0 = read
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_ack  out  1  one-cycle completion pulse
p0_rdata  out  DW  port 0 read data; valid while p0_ack=1, held until the next port-0 read ack
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
sram_a  out  AW  SRAM address
sram_dout  out  DW  data to pad
sram_oe  out  1  1 = top level drives sram_dout onto the pad
sram_din  in  DW  data from pad
sram_we_n  out  1  SRAM write strobe, active low
sram_rd_n  out  1  SRAM output enable, active low
busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Async reset (rst_n=0), applied immediately, even mid-cycle:
  - state=IDLE
  - sram_we_n=1, sram_rd_n=1, sram_oe=0
  - sram_a=0, sram_dout=0
  - p0_ack=p1_ack=0, p0_rdata=p1_rdata=0
  - last_grant=1, so port 0 wins the first tie.
- All outputs are registered.
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD.
- Eligibility: port N is eligible at an edge if pN_req=1 and pN_ack=0. A port whose ack is currently high is never re-granted on that edge, so a requester dropping req after ack causes no duplicate access.
- Arbitration in IDLE:
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - Update last_grant on every grant.
- Grant edge G latches addr, we, wdata and the port index; requester inputs are ignored until ack.
- Read, granted at edge G:
  - Edge G: sram_a<=addr, sram_rd_n<=0, go to RD_WAIT, counter=RD_CYCLES-1.
  - RD_WAIT counts down. At edge G+RD_CYCLES: rdata<=sram_din, ack<=1, sram_rd_n<=1, go to IDLE.
  - Ack is visible in cycle G+RD_CYCLES; the next grant is possible at edge G+RD_CYCLES+1.
- Write, granted at edge G:
  - Edge G: sram_a<=addr, sram_dout<=wdata, sram_oe<=1, state WR_SETUP (we_n stays 1; address/data setup).
  - Edge G+1: sram_we_n<=0, state WR_PULSE, counter=WE_CYCLES-1.
  - Edge G+1+WE_CYCLES: sram_we_n<=1, ack<=1, state WR_HOLD.
  - Edge G+2+WE_CYCLES: sram_oe<=0, go to IDLE. Address and data are held one cycle past the WE rising edge.
- Invariants:
  - sram_rd_n=0 and sram_oe=1 never at the same time.
  - sram_we_n=0 implies sram_oe=1 and an unchanged sram_a.
  - Each ack is exactly one cycle and goes only to the granted port.
  - sram_a keeps its last value in IDLE.
- The counter is sized for max(RD_CYCLES, WE_CYCLES); there is no wrap hazard.
- Requests are never dropped. A request deasserted before its ack is a protocol violation and is not checked.

Decomposition:
- Package sram_arb_pkg holds:
  - state encoding localparams (IDLE=0, RD_WAIT=1, WR_SETUP=2, WR_PULSE=3, WR_HOLD=4, 3-bit)
  - port index constants P0=0, P1=1
- Optional sub-module sram_arb_rr2: 2-way round-robin grant from req0/req1/last_grant, purely combinational.
- The sequencer stays in sram_arbiter.

Test Plan:
- Reset, then p0 read of addr 0x00010 with the SRAM model returning 0x5A (RD_CYCLES=2) -> sram_rd_n low for 2 cycles; p0_ack high at cycle G+2 with p0_rdata=0x5A; p1_ack stays 0.
- p1 write of 0xA5 to 0x1FFFFF -> sram_oe=1 from G; sram_we_n low exactly WE_CYCLES=2 cycles starting G+1; address/data stable from G to G+4; p1_ack at G+3; readback via p0 returns 0xA5.
- p0 and p1 both requesting reads continuously after reset -> grants alternate p0, p1, p0, ...; each port gets an ack every 2*(RD_CYCLES+1)=6 cycles.
- Requester drops req on the cycle after ack -> no second access is issued; busy=0 and the state returns to IDLE.
- rst_n asserted during WR_PULSE -> sram_we_n=1 and sram_oe=0 immediately (async); no ack is produced; after release, p0 is granted first on a tie.
- Randomised mix of reads and writes on both ports against a 2 MB behavioural SRAM -> every read returns the last value written; strobe invariants hold throughout.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
// State encoding, port indices and counter sizing.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Counter only ever holds values up to max(cycles)-1.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side req/ack bundle for one arbiter port.
// master = requester, slave = arbiter.
interface sram_arbiter_if #(
  parameter int AW = 21,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin grant, purely combinational.
// On a tie the port that did not win last time is chosen.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic idx
);

  always_comb begin
    valid = req0 | req1;
    idx   = P0;
    unique case (1'b1)
      (req0 & req1):  idx = ~last;
      (req1 & ~req0): idx = P1;
      default:        idx = P0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter and cycle sequencer sharing one async 8-bit SRAM
// between two req/ack ports; all SRAM-side outputs registered.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW        = 21,
  parameter int DW        = 8,
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave p0,
  sram_arbiter_if.slave p1,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_dout,
  output logic          sram_oe,
  input  logic [DW-1:0] sram_din,
  output logic          sram_we_n,
  output logic          sram_rd_n,
  output logic          busy
);

  localparam int CW = cnt_w(RD_CYCLES, WE_CYCLES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          port;
  logic [1:0]    ack;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          elig0;
  logic          elig1;
  logic          gnt;
  logic          gnt_idx;

  // A port whose ack is high this cycle is finishing, not asking again.
  assign elig0 = p0.req & ~ack[0];
  assign elig1 = p1.req & ~ack[1];

  sram_arb_rr2 u_rr2 (
    .req0  (elig0),
    .req1  (elig1),
    .last  (last),
    .valid (gnt),
    .idx   (gnt_idx)
  );

  assign p0.ack   = ack[0];
  assign p1.ack   = ack[1];
  assign p0.rdata = rdata0;
  assign p1.rdata = rdata1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= P1;
      port      <= P0;
      ack       <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      sram_a    <= '0;
      sram_dout <= '0;
      sram_oe   <= 1'b0;
      sram_we_n <= 1'b1;
      sram_rd_n <= 1'b1;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (gnt) begin
            last   <= gnt_idx;
            port   <= gnt_idx;
            sram_a <= gnt_idx ? p1.addr : p0.addr;
            if (gnt_idx ? p1.we : p0.we) begin
              sram_dout <= gnt_idx ? p1.wdata : p0.wdata;
              sram_oe   <= 1'b1;
              state     <= WR_SETUP;
            end else begin
              sram_rd_n <= 1'b0;
              cnt       <= CW'(RD_CYCLES - 1);
              state     <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            if (port == P1) rdata1 <= sram_din;
            else            rdata0 <= sram_din;
            ack[port] <= 1'b1;
            sram_rd_n <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WR_SETUP: begin
          sram_we_n <= 1'b0;
          cnt       <= CW'(WE_CYCLES - 1);
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            ack[port] <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WR_HOLD: begin
          sram_oe <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
